button_press_classifier: RTL and testbench

Converts one raw, bouncing push-button into the clean single-cycle `inc_short` and `inc_long` strobes consumed by the FSM and counter. Inside: a synchronizer, a debouncer and a hold-time classifier. It is the producer side of the inc-button interface and sits between the board pin and the FSM. One instance per button; runs on the counter clock domain.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/button_press_classifier.sv | 121 ++++++++++++
 tb/tb_button_press_classifier.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: classifier state type,
// 10 kHz default timing constants and a counter-width helper.
package btn_pkg;

   // Classifier state: waiting for a press, pressed and timing, long press seen
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } btn_state_e;

   // Defaults for a 10 kHz counter clock
   localparam int DEBOUNCE_CYCLES = 200;    // 20 ms
   localparam int LONG_CYCLES     = 10000;  // 1 s
   localparam int REPEAT_CYCLES   = 2000;   // 200 ms

   // Counter width for a counter that runs 0 .. n-1; never narrower than 1 bit
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizer plus debouncer for one raw push-button. A level change on the
// synchronized input is accepted only after DEBOUNCE_CYCLES consecutive cycles
// of disagreement with the current debounced level; shorter glitches vanish.
// Also used for the set and sw buttons.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_db
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   s;

   assign s      = sync_q[SYNC_STAGES-1];
   assign btn_db = db_q;

   // Shift the raw pin through the synchronizer; count disagreement cycles
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
      cnt_d  = cnt_q;
      db_d   = db_q;
      if (s == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         db_d  = ~db_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
      end
   end

endmodule

// File: rtl/button_press_classifier.sv
// Turns one bouncing push-button into clean single-cycle inc_short / inc_long
// strobes. A press held for LONG_CYCLES cycles gives inc_long; a shorter one
// gives inc_short on release.
// Optional feature: define BTN_AUTOREPEAT_EN to repeat inc_long every
// REPEAT_CYCLES cycles while the button stays held after the first inc_long.
module button_press_classifier
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = btn_pkg::LONG_CYCLES,
   parameter int REPEAT_CYCLES   = btn_pkg::REPEAT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_db,
   output logic inc_short,
   output logic inc_long
);

   localparam int HW = cnt_width(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

   btn_state_e    state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          inc_short_q, inc_short_d;
   logic          inc_long_q, inc_long_d;
   logic          db;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = cnt_width(REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

   btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw),
      .btn_db  (db)
   );

   assign btn_db    = db;
   assign inc_short = inc_short_q;
   assign inc_long  = inc_long_q;

   // Next-state and strobe logic; a release in HELD wins over the long threshold
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      inc_short_d = 1'b0;
      inc_long_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_d   = rep_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (db) begin
               state_d    = HELD;
               hold_cnt_d = '0;
            end
         end
         HELD: begin
            if (!db) begin
               state_d     = IDLE;
               inc_short_d = 1'b1;
            end else if (hold_cnt_q == HOLD_MAX) begin
               state_d    = LONG;
               inc_long_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
               rep_cnt_d  = '0;
`endif
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         LONG: begin
            if (!db) begin
               state_d = IDLE;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (rep_cnt_q == REP_MAX) begin
               inc_long_d = 1'b1;
               rep_cnt_d  = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, counters and registered strobes with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         inc_short_q <= 1'b0;
         inc_long_q  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rep_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         inc_short_q <= inc_short_d;
         inc_long_q  <= inc_long_d;
`ifdef BTN_AUTOREPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier with short timing constants. A reference
// model computes the debounced level and the strobes from press durations.
module tb_button_press_classifier;
   import btn_pkg::*;

   localparam int SYNC  = 2;
   localparam int DEB   = 4;
   localparam int LONGC = 20;
   localparam int REP   = 8;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic reset;
   logic btn_raw;
   logic btn_db;
   logic inc_short;
   logic inc_long;

   always #5 clk = ~clk;

   button_press_classifier #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LONGC),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .btn_db    (btn_db),
      .inc_short (inc_short),
      .inc_long  (inc_long)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // m_pipe: raw level as seen through the synchronizer delay line
   // m_run : consecutive cycles the synced level disagreed with m_db
   // m_r   : index of the previous cycle within the current press (0 = first db=1 cycle)
   bit m_pipe [SYNC];
   bit m_s, m_db, m_short, m_long, m_in_press;
   int m_run, m_r;

   task automatic model_edge(input bit raw_in, input bit rst_in);
      if (rst_in) begin
         for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
         m_s = 0; m_db = 0; m_run = 0; m_r = 0;
         m_in_press = 0; m_short = 0; m_long = 0;
      end else begin
         m_short = 0;
         m_long  = 0;
         // strobes from the press timeline of the previous cycle
         if (m_in_press) begin
            m_r++;
            if (!m_db) begin
               m_short    = (m_r <= LONGC);
               m_in_press = 0;
            end else if (m_r == LONGC) begin
               m_long = 1;
            end else if (AUTO && m_r > LONGC && ((m_r - LONGC) % REP) == 0) begin
               m_long = 1;
            end
         end else if (m_db) begin
            m_in_press = 1;
            m_r        = 0;
         end
         // level accepted after DEB consecutive disagreeing cycles
         if (m_s != m_db) begin
            m_run++;
            if (m_run == DEB) begin
               m_db  = ~m_db;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = raw_in;
         m_s       = m_pipe[SYNC-1];
      end
   endtask

   // ---------------- scenario recorders ----------------
   int t;
   int n_short, n_long, short_at, db_rise_at, db_fall_at, st46, st47, out16;
   int long_at [4];
   bit db_seen, db_prev;

   task automatic clear_rec();
      t = 0; n_short = 0; n_long = 0; short_at = -1;
      db_rise_at = -1; db_fall_at = -1; st46 = -1; st47 = -1; out16 = -1;
      db_seen = 0; db_prev = btn_db;
      for (int i = 0; i < 4; i++) long_at[i] = -1;
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit raw_v, input bit rst_v);
      btn_raw = raw_v;
      reset   = rst_v;
      @(posedge clk);
      t++;
      model_edge(raw_v, rst_v);
      #1;
      check_eq($sformatf("btn_db@%0d", t), int'(btn_db), int'(m_db));
      check_eq($sformatf("inc_short@%0d", t), int'(inc_short), int'(m_short));
      check_eq($sformatf("inc_long@%0d", t), int'(inc_long), int'(m_long));
      if (inc_short) begin n_short++; short_at = t; end
      if (inc_long) begin
         if (n_long < 4) long_at[n_long] = t;
         n_long++;
      end
      if (btn_db && !db_prev) db_rise_at = t;
      if (!btn_db && db_prev) db_fall_at = t;
      if (btn_db) db_seen = 1;
      db_prev = btn_db;
      if (t == 16) out16 = {29'd0, btn_db, inc_short, inc_long};
      if (t == 46) st46 = int'(dut.state_q);
      if (t == 47) st47 = int'(dut.state_q);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit cur;
      reset   = 1'b1;
      btn_raw = 1'b0;
      model_edge(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b1);
      check_eq("reset_state", int'(dut.state_q), int'(IDLE));
      repeat (2) step(1'b0, 1'b0);

      // 1: short glitches are rejected
      clear_rec();
      for (int w = 1; w <= 3; w++) begin
         repeat (w) step(1'b1, 1'b0);
         repeat (5) step(1'b0, 1'b0);
      end
      repeat (10) step(1'b0, 1'b0);
      check_eq("t1_db_seen", int'(db_seen), 0);
      check_eq("t1_n_short", n_short, 0);
      check_eq("t1_n_long", n_long, 0);

      // 2: 10-cycle press -> short
      clear_rec();
      repeat (10) step(1'b1, 1'b0);
      repeat (30) step(1'b0, 1'b0);
      check_eq("t2_db_rise", db_rise_at, 6);
      check_eq("t2_db_fall", db_fall_at, 16);
      check_eq("t2_n_short", n_short, 1);
      check_eq("t2_short_at", short_at, 17);
      check_eq("t2_n_long", n_long, 0);

      // 3/4: 40-cycle press -> long (plus repeats when enabled)
      clear_rec();
      repeat (40) step(1'b1, 1'b0);
      repeat (40) step(1'b0, 1'b0);
      check_eq("t3_n_long", n_long, AUTO ? 3 : 1);
      check_eq("t3_long0", long_at[0], 27);
      check_eq("t3_long1", long_at[1], AUTO ? 35 : -1);
      check_eq("t3_long2", long_at[2], AUTO ? 43 : -1);
      check_eq("t3_n_short", n_short, 0);
      check_eq("t3_state46", st46, int'(LONG));
      check_eq("t3_state47", st47, int'(IDLE));

      // 5a: fall exactly at the long threshold -> short
      clear_rec();
      repeat (20) step(1'b1, 1'b0);
      repeat (30) step(1'b0, 1'b0);
      check_eq("t5a_n_short", n_short, 1);
      check_eq("t5a_short_at", short_at, 27);
      check_eq("t5a_n_long", n_long, 0);

      // 5b: one cycle longer -> long
      clear_rec();
      repeat (21) step(1'b1, 1'b0);
      repeat (30) step(1'b0, 1'b0);
      check_eq("t5b_n_long", n_long, 1);
      check_eq("t5b_long_at", long_at[0], 27);
      check_eq("t5b_n_short", n_short, 0);

      // 6: reset mid-press; the still-held button is re-debounced
      clear_rec();
      for (int i = 0; i < 30; i++) step(1'b1, i == 15);
      repeat (40) step(1'b0, 1'b0);
      check_eq("t6_out16", out16, 0);
      check_eq("t6_db_rerise", db_rise_at, 22);
      check_eq("t6_n_long", n_long, 0);
      check_eq("t6_n_short", n_short, 1);
      check_eq("t6_short_at", short_at, 37);

      // random bouncing presses with occasional resets
      cur = 1'b0;
      for (int p = 0; p < 40; p++) begin
         int bounce, hold, gap;
         bounce = $urandom_range(0, 3);
         for (int b = 0; b < bounce; b++) step(1'($urandom_range(0, 1)), 1'b0);
         hold = $urandom_range(1, 45);
         for (int h = 0; h < hold; h++) begin
            step(1'b1, ($urandom_range(0, 299) == 0));
         end
         bounce = $urandom_range(0, 3);
         for (int b = 0; b < bounce; b++) step(1'($urandom_range(0, 1)), 1'b0);
         gap = $urandom_range(3, 30);
         for (int g = 0; g < gap; g++) begin
            cur = ($urandom_range(0, 19) == 0);
            step(cur, 1'b0);
         end
      end
      repeat (40) step(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
